// File: rtl/sha_nonce_scheduler_if.sv
// SHA core link: message and start pulse out to the core, completion and digest back.
`timescale 1ns/1ps
interface sha_nonce_scheduler_if #(
    parameter int MSG_SIZE = 640
);
    logic [MSG_SIZE-1:0] sha_msg;
    logic                sha_begin;
    logic                sha_complete;
    logic [255:0]        sha_digest;

    modport master (
        output sha_msg,
        output sha_begin,
        input  sha_complete,
        input  sha_digest
    );

    modport slave (
        input  sha_msg,
        input  sha_begin,
        output sha_complete,
        output sha_digest
    );
endinterface

// File: rtl/sha_nonce_scheduler.sv
// Nonce search sequencer: issues one SHA computation per nonce over an inclusive
// range and stops at the first digest below target, on exhaustion, or on abort.
`timescale 1ns/1ps
module sha_nonce_scheduler #(
    parameter int MSG_SIZE = 640,
    parameter int NONCE_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [MSG_SIZE-NONCE_W-1:0] header_in,
    input  logic [NONCE_W-1:0]          nonce_start,
    input  logic [NONCE_W-1:0]          nonce_end,
    input  logic [255:0]                target,
    sha_nonce_scheduler_if.master       sha,
    output logic                        busy,
    output logic                        found,
    output logic                        exhausted,
    output logic                        aborted,
    output logic [NONCE_W-1:0]          found_nonce,
    output logic [255:0]                found_hash,
    output logic [NONCE_W-1:0]          hash_count
);
    localparam int HDR_W = MSG_SIZE - NONCE_W;
    localparam logic [NONCE_W-1:0] ONE = {{(NONCE_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_begin;
    logic [HDR_W-1:0]     r_header;
    logic [NONCE_W-1:0]   r_nonce;
    logic [NONCE_W-1:0]   r_nonce_end;
    logic [255:0]         r_target;
    logic [255:0]         r_digest;
    logic [MSG_SIZE-1:0]  r_msg;
    logic                 r_first;
    logic                 r_found;
    logic                 r_exhausted;
    logic                 r_aborted;
    logic [NONCE_W-1:0]   r_found_nonce;
    logic [255:0]         r_found_hash;
    logic [NONCE_W-1:0]   r_count;

    // Completion is only trusted after the first WAIT cycle; the core's level may still
    // reflect the previous computation in the cycle right after sha_begin.
    logic                 w_complete;
    logic                 w_hit;
    logic                 w_last;
    logic                 w_empty;
    logic [NONCE_W-1:0]   w_nonce_nxt;

    assign w_complete  = sha.sha_complete & ~r_first;
    assign w_hit       = r_digest < r_target;
    assign w_last      = r_nonce == r_nonce_end;
    assign w_empty     = r_nonce_end < r_nonce;
    assign w_nonce_nxt = r_nonce + ONE;

    function automatic logic [NONCE_W-1:0] sat_inc(input logic [NONCE_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and begin pulse; the pulse is withheld if abort arrives in ISSUE.
    always_comb begin
        w_next  = r_state;
        w_begin = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  begin
                if (abort || w_empty) w_next = S_IDLE;
                else                  w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (abort) w_next = S_IDLE;
                else begin
                    w_begin = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT:  begin
                if (abort)           w_next = w_complete ? S_IDLE : S_DRAIN;
                else if (w_complete) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (abort || w_hit || w_last) w_next = S_IDLE;
                else                          w_next = S_ISSUE;
            end
            S_DRAIN: if (sha.sha_complete) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Search context, message register, result flags and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_header      <= '0;
            r_nonce       <= '0;
            r_nonce_end   <= '0;
            r_target      <= '0;
            r_digest      <= '0;
            r_msg         <= '0;
            r_first       <= 1'b0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_aborted     <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
            r_count       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_header    <= header_in;
                        r_nonce     <= nonce_start;
                        r_nonce_end <= nonce_end;
                        r_target    <= target;
                        r_found     <= 1'b0;
                        r_exhausted <= 1'b0;
                        r_aborted   <= 1'b0;
                        r_count     <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort)        r_aborted   <= 1'b1;
                    else if (w_empty) r_exhausted <= 1'b1;
                    else              r_msg       <= {r_header, r_nonce};
                end
                S_ISSUE: begin
                    if (abort) r_aborted <= 1'b1;
                    else       r_first   <= 1'b1;
                end
                S_WAIT: begin
                    r_first <= 1'b0;
                    if (abort) begin
                        if (w_complete) r_aborted <= 1'b1;
                    end else if (w_complete) begin
                        r_digest <= sha.sha_digest;
                        r_count  <= sat_inc(r_count);
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                    end else if (w_hit) begin
                        r_found       <= 1'b1;
                        r_found_nonce <= r_nonce;
                        r_found_hash  <= r_digest;
                    end else if (w_last) begin
                        r_exhausted <= 1'b1;
                    end else begin
                        r_nonce <= w_nonce_nxt;
                        r_msg   <= {r_header, w_nonce_nxt};
                    end
                end
                S_DRAIN: begin
                    if (sha.sha_complete) r_aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sha.sha_msg   = r_msg;
    assign sha.sha_begin = w_begin;
    assign busy          = r_state != S_IDLE;
    assign found         = r_found;
    assign exhausted     = r_exhausted;
    assign aborted       = r_aborted;
    assign found_nonce   = r_found_nonce;
    assign found_hash    = r_found_hash;
    assign hash_count    = r_count;
endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Bench for sha_nonce_scheduler: stub SHA core, vector table, random searches
// against a loop-based reference model, and hand-timed abort/reset/latency cases.
`timescale 1ns/1ps
module tb_sha_nonce_scheduler;
    localparam int MSG_SIZE = 640;
    localparam int NONCE_W  = 32;
    localparam int HDR_W    = MSG_SIZE - NONCE_W;
    localparam logic [255:0] REF_DIG =
        256'h12ab50d488d6ed958b8a51e32137b70a37609a92b7222046cccfad644c8a3f6b;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [HDR_W-1:0]   header_in = '0;
    logic [31:0]        nonce_start = '0;
    logic [31:0]        nonce_end = '0;
    logic [255:0]       target = '0;
    logic               busy, found, exhausted, aborted;
    logic [31:0]        found_nonce, hash_count;
    logic [255:0]       found_hash;

    int checks = 0;
    int failures = 0;

    sha_nonce_scheduler_if #(.MSG_SIZE(MSG_SIZE)) bus();

    sha_nonce_scheduler #(.MSG_SIZE(MSG_SIZE), .NONCE_W(NONCE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .header_in(header_in), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .sha(bus),
        .busy(busy), .found(found), .exhausted(exhausted), .aborted(aborted),
        .found_nonce(found_nonce), .found_hash(found_hash), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    // Stub core digest: mode 0 = nonce, 1 = fixed value, 2 = scrambled upper word.
    int           stub_mode = 0;
    int           stub_lat  = 4;
    logic [255:0] fixed_dig = REF_DIG;

    function automatic logic [255:0] hash_of(input logic [31:0] n, input int mode,
                                             input logic [255:0] fx);
        case (mode)
            0:       return {224'd0, n};
            1:       return fx;
            default: return {(n * 32'h9E3779B1) ^ 32'h5BD1E995, 192'd0, n};
        endcase
    endfunction

    // Stub core: complete level stays high until one cycle after the next begin.
    logic        stub_done;
    int          stub_cnt;
    logic [31:0] stub_nonce;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_done  <= 1'b0;
            stub_cnt   <= 0;
            stub_nonce <= '0;
        end else if (bus.sha_begin === 1'b1) begin
            stub_cnt   <= stub_lat;
            stub_nonce <= bus.sha_msg[31:0];
        end else if (stub_cnt > 1) begin
            stub_cnt  <= stub_cnt - 1;
            stub_done <= 1'b0;
        end else if (stub_cnt == 1) begin
            stub_cnt  <= 0;
            stub_done <= 1'b1;
        end
    end
    assign bus.sha_complete = stub_done;
    assign bus.sha_digest   = hash_of(stub_nonce, stub_mode, fixed_dig);

    // Every issued message is recorded for later comparison.
    logic [31:0]      seen_n[$];
    logic [HDR_W-1:0] seen_h[$];
    always @(negedge clk) begin
        if (bus.sha_begin === 1'b1) begin
            seen_n.push_back(bus.sha_msg[31:0]);
            seen_h.push_back(bus.sha_msg[MSG_SIZE-1:NONCE_W]);
        end
    end

    typedef struct {
        logic [31:0]  s;
        logic [31:0]  e;
        logic [255:0] t;
        int           mode;
        logic         ef;
        logic         ee;
        logic [31:0]  en;
        logic [255:0] eh;
        logic [31:0]  ec;
    } vec_t;

    vec_t             tbl[6];
    logic [HDR_W-1:0] hdr;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_hdr(input string name, input logic [HDR_W-1:0] act,
                           input logic [HDR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: walk the range in order, count digests, stop at the first one below target.
    function automatic vec_t model(input logic [31:0] s, input logic [31:0] e,
                                   input logic [255:0] t, input int mode);
        vec_t v;
        logic [255:0] h;
        v.s = s; v.e = e; v.t = t; v.mode = mode;
        v.ef = 1'b0; v.ee = 1'b0; v.en = '0; v.eh = '0; v.ec = '0;
        for (longint n = longint'(s); n <= longint'(e); n++) begin
            v.ec = v.ec + 32'd1;
            h = hash_of(32'(n), mode, fixed_dig);
            if (h < t) begin
                v.ef = 1'b1; v.en = 32'(n); v.eh = h;
                break;
            end
        end
        if (!v.ef) v.ee = 1'b1;
        return v;
    endfunction

    task automatic kick(input logic [HDR_W-1:0] h, input logic [31:0] s,
                        input logic [31:0] e, input logic [255:0] t);
        @(posedge clk); #1;
        header_in = h; nonce_start = s; nonce_end = e; target = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        check({tag, " idle_timeout_busy"}, 256'(busy), 256'(0));
    endtask

    task automatic wait_begin(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sha_begin !== 1'b1 && n < 200);
        check({tag, " begin_timeout"}, 256'(bus.sha_begin), 256'(1));
    endtask

    task automatic wait_complete(input string tag);
        int n;
        n = 0;
        while (bus.sha_complete !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " complete_timeout"}, 256'(bus.sha_complete), 256'(1));
    endtask

    task automatic verify_issues(input string tag, input int base, input logic [HDR_W-1:0] h,
                                 input logic [31:0] s, input int n);
        int got;
        got = seen_n.size() - base;
        check({tag, " begins"}, 256'(got), 256'(n));
        for (int i = 0; i < n && i < got; i++) begin
            logic [31:0] en;
            en = s + 32'(i);
            check({tag, " nonce"}, 256'(seen_n[base + i]), 256'(en));
            chk_hdr({tag, " header"}, seen_h[base + i], h);
        end
    endtask

    task automatic do_run(input string tag, input vec_t v, input logic [HDR_W-1:0] h);
        int base;
        base = seen_n.size();
        stub_mode = v.mode;
        kick(h, v.s, v.e, v.t);
        wait_idle(tag);
        check({tag, " found"}, 256'(found), 256'(v.ef));
        check({tag, " exhausted"}, 256'(exhausted), 256'(v.ee));
        check({tag, " aborted"}, 256'(aborted), 256'(0));
        check({tag, " hash_count"}, 256'(hash_count), 256'(v.ec));
        if (v.ef) begin
            check({tag, " found_nonce"}, 256'(found_nonce), 256'(v.en));
            check({tag, " found_hash"}, found_hash, v.eh);
        end
        verify_issues(tag, base, h, v.s, int'(v.ec));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vec_t v;

        tbl[0] = '{32'd1, 32'd1, REF_DIG + 256'd1, 1, 1'b1, 1'b0, 32'd1, REF_DIG, 32'd1};
        tbl[1] = '{32'd1, 32'd1, REF_DIG, 1, 1'b0, 1'b1, 32'd0, 256'd0, 32'd1};
        tbl[2] = '{32'd10, 32'd20, 256'd15, 0, 1'b1, 1'b0, 32'd10, 256'd10, 32'd1};
        tbl[3] = '{32'd10, 32'd20, 256'd5, 0, 1'b0, 1'b1, 32'd0, 256'd0, 32'd11};
        tbl[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'd0, 0, 1'b0, 1'b1, 32'd0, 256'd0, 32'd2};
        tbl[5] = '{32'd7, 32'd3, 256'd0, 0, 1'b0, 1'b1, 32'd0, 256'd0, 32'd0};
        for (int k = 0; k < HDR_W / 32; k++) hdr[k*32 +: 32] = 32'hA5A50000 + 32'(k);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", 256'(busy), 256'(0));
        check("rst sha_begin", 256'(bus.sha_begin), 256'(0));
        check("rst sha_msg", 256'(|bus.sha_msg), 256'(0));
        check("rst flags", 256'({found, exhausted, aborted}), 256'(0));
        check("rst hash_count", 256'(hash_count), 256'(0));
        check("rst found_hash", found_hash, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Vector table
        stub_lat = 4;
        for (int i = 0; i < 6; i++) do_run($sformatf("vec%0d", i), tbl[i], hdr);

        // Cycle latency: begin two cycles after start and two after completion
        stub_mode = 0;
        base = seen_n.size();
        @(posedge clk); #1;
        header_in = hdr; nonce_start = 32'd10; nonce_end = 32'd11; target = '0; start = 1'b1;
        @(negedge clk);
        check("lat c0 begin", 256'(bus.sha_begin), 256'(0));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("lat c1 begin", 256'(bus.sha_begin), 256'(0));
        check("lat c1 busy", 256'(busy), 256'(1));
        @(negedge clk);
        check("lat c2 begin", 256'(bus.sha_begin), 256'(1));
        @(negedge clk);
        @(negedge clk);
        wait_complete("lat");
        @(negedge clk);
        check("lat N+1 begin", 256'(bus.sha_begin), 256'(0));
        @(negedge clk);
        check("lat N+2 begin", 256'(bus.sha_begin), 256'(1));
        wait_idle("lat");
        check("lat exhausted", 256'(exhausted), 256'(1));
        check("lat hash_count", 256'(hash_count), 256'(2));
        verify_issues("lat", base, hdr, 32'd10, 2);

        // Abort while waiting on the core, with an ignored start in between
        base = seen_n.size();
        kick(hdr, 32'd10, 32'd20, 256'd0);
        wait_begin("abw first");
        @(posedge clk); #1;
        header_in = ~hdr; nonce_start = 32'd100; nonce_end = 32'd200; target = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_begin("abw second");
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abw drain busy", 256'(busy), 256'(1));
        wait_idle("abw");
        check("abw aborted", 256'(aborted), 256'(1));
        check("abw found", 256'(found), 256'(0));
        check("abw exhausted", 256'(exhausted), 256'(0));
        check("abw hash_count", 256'(hash_count), 256'(1));
        repeat (5) @(negedge clk);
        verify_issues("abw", base, hdr, 32'd10, 2);
        v = model(32'd3, 32'd4, 256'd0, 0);
        do_run("after_abort", v, hdr);

        // Abort arriving in the same cycle as a hit: abort wins
        base = seen_n.size();
        kick(hdr, 32'd10, 32'd20, 256'd15);
        wait_begin("abc");
        @(negedge clk);
        @(negedge clk);
        wait_complete("abc");
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle("abc");
        check("abc found", 256'(found), 256'(0));
        check("abc aborted", 256'(aborted), 256'(1));
        check("abc hash_count", 256'(hash_count), 256'(1));
        verify_issues("abc", base, hdr, 32'd10, 1);

        // Abort while idle leaves the sticky result alone
        v = model(32'd20, 32'd30, 256'd25, 0);
        do_run("pre_idle_abort", v, hdr);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort found", 256'(found), 256'(1));
        check("idle_abort aborted", 256'(aborted), 256'(0));
        check("idle_abort busy", 256'(busy), 256'(0));

        // Asynchronous reset in the middle of WAIT
        kick(hdr, 32'd10, 32'd20, 256'd0);
        for (int n = 0; n < 300 && hash_count != 32'd3; n++) @(negedge clk);
        check("rstw hash_count reached", 256'(hash_count), 256'(3));
        wait_begin("rstw");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstw busy", 256'(busy), 256'(0));
        check("rstw sha_begin", 256'(bus.sha_begin), 256'(0));
        check("rstw sha_msg", 256'(|bus.sha_msg), 256'(0));
        check("rstw flags", 256'({found, exhausted, aborted}), 256'(0));
        check("rstw found_nonce", 256'(found_nonce), 256'(0));
        check("rstw found_hash", found_hash, 256'(0));
        check("rstw hash_count", 256'(hash_count), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        v = model(32'd3, 32'd5, 256'd4, 0);
        do_run("after_rst", v, hdr);

        // Randomized searches against the reference model
        for (int r = 0; r < 40; r++) begin
            logic [31:0]  s, e;
            logic [255:0] t;
            vec_t         rv;
            for (int k = 0; k < HDR_W / 32; k++) hdr[k*32 +: 32] = $urandom;
            s = $urandom;
            if ($urandom_range(0, 7) == 0) s = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
            e = s + 32'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) e = s - 32'($urandom_range(1, 5));
            for (int k = 0; k < 7; k++) t[k*32 +: 32] = $urandom;
            t[255:224] = 32'($urandom_range(0, 32'h3000_0000));
            stub_lat = $urandom_range(1, 6);
            rv = model(s, e, t, 2);
            do_run($sformatf("rand%0d", r), rv, hdr);
            check("rand flags exclusive",
                  256'((32'(found) + 32'(exhausted) + 32'(aborted)) <= 32'd1), 256'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
